// File: rtl/reg8_seq_pkg.sv
// Shared types for the 8-bit register command sequencer: opcodes, FSM states
// and the packed command word held in the FIFO.
package reg8_seq_pkg;

   localparam int SEQ_TAG_W = 4;

   typedef enum logic [1:0] {
      OP_READ = 2'b00,
      OP_LOAD = 2'b01,
      OP_SHL  = 2'b10,
      OP_SHR  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_SAMPLE,
      S_RESP
   } state_e;

   typedef struct packed {
      op_e                  op;
      logic [2:0]           amt;
      logic [7:0]           data;
      logic [SEQ_TAG_W-1:0] tag;
   } cmd_t;

endpackage

// File: rtl/reg8_cmd_fifo.sv
// Command FIFO: DEPTH entries of cmd_t, wrapping pointers plus an occupancy
// count so full and empty are unambiguous.
module reg8_cmd_fifo
   import reg8_seq_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic push,
   input  logic pop,
   input  cmd_t din,
   output cmd_t dout,
   output logic full,
   output logic empty
);

   localparam int PW = $clog2(DEPTH);

   cmd_t          mem_q [DEPTH];
   cmd_t          mem_d [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW:0]   count_q, count_d;
   logic          do_push, do_pop;

   assign full    = (count_q == (PW+1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem_q[rd_ptr_q];

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = din;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop)
         rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset; occupancy is governed by count_q alone.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/reg8_cmd_sequencer.sv
// Command sequencer for the 8-bit shift/load register: queues commands,
// pulses the register controls for one cycle, returns the result with its tag.
// Optional SEQ_STATS_EN enables the completed-command counter on stat_count.
module reg8_cmd_sequencer
   import reg8_seq_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int TAG_W = SEQ_TAG_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [2:0]       cmd_amt,
   input  logic [7:0]       cmd_data,
   input  logic [TAG_W-1:0] cmd_tag,
   output logic             reg_load,
   output logic             reg_shift_r_l,
   output logic [2:0]       reg_sh,
   output logic [7:0]       reg_d_in,
   input  logic [7:0]       reg_d_out,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [7:0]       rsp_data,
   output logic [TAG_W-1:0] rsp_tag,
   output logic [15:0]      stat_count
);

   cmd_t push_cmd, head;
   logic fifo_full, fifo_empty, fifo_pop;

   assign push_cmd = '{op: op_e'(cmd_op), amt: cmd_amt, data: cmd_data, tag: cmd_tag};
   assign cmd_ready = !fifo_full;

   reg8_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (cmd_valid),
      .pop   (fifo_pop),
      .din   (push_cmd),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   state_e           state_q, state_d;
   logic [TAG_W-1:0] cur_tag_q, cur_tag_d;
   logic             reg_load_q, reg_load_d;
   logic             reg_srl_q, reg_srl_d;
   logic [2:0]       reg_sh_q, reg_sh_d;
   logic [7:0]       reg_d_in_q, reg_d_in_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic [7:0]       rsp_data_q, rsp_data_d;
   logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;

   assign fifo_pop = (state_q == S_IDLE) && !fifo_empty;

   // Register controls are decoded on the pop so they are live exactly for
   // the ISSUE cycle; only the tag of the command is needed after that.
   always_comb begin
      state_d     = state_q;
      cur_tag_d   = cur_tag_q;
      reg_load_d  = 1'b0;
      reg_srl_d   = 1'b0;
      reg_sh_d    = '0;
      reg_d_in_d  = '0;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      rsp_tag_d   = rsp_tag_q;
      case (state_q)
         S_IDLE: if (!fifo_empty) begin
            cur_tag_d = head.tag;
            state_d   = S_ISSUE;
            case (head.op)
               OP_LOAD: begin reg_load_d = 1'b1; reg_d_in_d = head.data; end
               OP_SHL:  reg_sh_d = head.amt;
               OP_SHR:  begin reg_srl_d = 1'b1; reg_sh_d = head.amt; end
               default: ;
            endcase
         end
         S_ISSUE:  state_d = S_SAMPLE;
         S_SAMPLE: begin
            rsp_data_d  = reg_d_out;
            rsp_tag_d   = cur_tag_q;
            rsp_valid_d = 1'b1;
            state_d     = S_RESP;
         end
         S_RESP: if (rsp_ready) begin
            rsp_valid_d = 1'b0;
            state_d     = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cur_tag_q   <= '0;
         reg_load_q  <= 1'b0;
         reg_srl_q   <= 1'b0;
         reg_sh_q    <= '0;
         reg_d_in_q  <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_tag_q   <= '0;
      end else begin
         state_q     <= state_d;
         cur_tag_q   <= cur_tag_d;
         reg_load_q  <= reg_load_d;
         reg_srl_q   <= reg_srl_d;
         reg_sh_q    <= reg_sh_d;
         reg_d_in_q  <= reg_d_in_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_tag_q   <= rsp_tag_d;
      end
   end

   assign reg_load      = reg_load_q;
   assign reg_shift_r_l = reg_srl_q;
   assign reg_sh        = reg_sh_q;
   assign reg_d_in      = reg_d_in_q;
   assign rsp_valid     = rsp_valid_q;
   assign rsp_data      = rsp_data_q;
   assign rsp_tag       = rsp_tag_q;

`ifdef SEQ_STATS_EN
   logic [15:0] stat_count_q, stat_count_d;

   always_comb begin
      stat_count_d = stat_count_q;
      if (rsp_valid_q && rsp_ready)
         stat_count_d = stat_count_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) stat_count_q <= '0;
      else       stat_count_q <= stat_count_d;
   end

   assign stat_count = stat_count_q;
`else
   assign stat_count = '0;
`endif

endmodule

// File: tb/tb_reg8_cmd_sequencer.sv
// Bench for reg8_cmd_sequencer: behavioural 8-bit register on the reg_* side,
// expected responses queued at command acceptance and popped on handshake.
module tb_reg8_cmd_sequencer;

   localparam int TW = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          cmd_valid, cmd_ready;
   logic [1:0]    cmd_op;
   logic [2:0]    cmd_amt;
   logic [7:0]    cmd_data;
   logic [TW-1:0] cmd_tag;
   logic          reg_load, reg_shift_r_l;
   logic [2:0]    reg_sh;
   logic [7:0]    reg_d_in, reg_d_out;
   logic          rsp_valid, rsp_ready;
   logic [7:0]    rsp_data;
   logic [TW-1:0] rsp_tag;
   logic [15:0]   stat_count;

   always #5 clk = ~clk;

   reg8_cmd_sequencer #(.DEPTH(4), .TAG_W(TW)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_amt(cmd_amt), .cmd_data(cmd_data), .cmd_tag(cmd_tag),
      .reg_load(reg_load), .reg_shift_r_l(reg_shift_r_l), .reg_sh(reg_sh),
      .reg_d_in(reg_d_in), .reg_d_out(reg_d_out),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_tag(rsp_tag), .stat_count(stat_count)
   );

   // Downstream shift/load register, ones shifted into vacated bits.
   always_ff @(posedge clk) begin
      if (reset)          reg_d_out <= 8'h00;
      else if (reg_load)  reg_d_out <= reg_d_in;
      else if (reg_sh != 3'd0) begin
         if (reg_shift_r_l) reg_d_out <= (reg_d_out >> reg_sh) | ~(8'hFF >> reg_sh);
         else               reg_d_out <= (reg_d_out << reg_sh) | ((8'h01 << reg_sh) - 8'h01);
      end
   end

   int npass = 0, nchk = 0;
   int load_cnt, rsp_cnt, hs_cnt;
   logic [7:0] load_din, shadow;
   logic sh_seen, obs_load, acc;
   logic [8+TW-1:0] exp_q[$];

   function automatic logic [7:0] model(input logic [1:0] op, input logic [2:0] amt,
                                        input logic [7:0] data, input logic [7:0] cur);
      case (op)
         2'b01:   return data;
         2'b10:   return 8'((16'(cur) << amt) | ((16'd1 << amt) - 16'd1));
         2'b11:   return 8'((cur >> amt) | ~(8'hFF >> amt));
         default: return cur;
      endcase
   endfunction

   // One clock: observe at the falling edge, retire any response handshake
   // against the queue, then return 1 time unit after the rising edge.
   task automatic step();
      logic [8+TW-1:0] e;
      @(negedge clk);
      if (reg_load) begin load_cnt++; load_din = reg_d_in; end
      if (reg_sh != 3'd0) sh_seen = 1'b1;
      obs_load = reg_load;
      acc = cmd_valid && cmd_ready;
      if (rsp_valid && rsp_ready) begin
         rsp_cnt++; hs_cnt++; nchk++;
         if (exp_q.size() == 0)
            $display("FAIL rsp_unexpected: got data=%h tag=%h, required no response", rsp_data, rsp_tag);
         else begin
            e = exp_q.pop_front();
            if ({rsp_data, rsp_tag} !== e)
               $display("FAIL rsp_scoreboard: got data=%h tag=%h, required data=%h tag=%h",
                        rsp_data, rsp_tag, e[8+TW-1:TW], e[TW-1:0]);
            else npass++;
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic push(input logic [1:0] op, input logic [2:0] amt,
                       input logic [7:0] data, input logic [TW-1:0] tag);
      cmd_valid = 1'b1; cmd_op = op; cmd_amt = amt; cmd_data = data; cmd_tag = tag;
      acc = 1'b0;
      for (int i = 0; i < 40 && !acc; i++) step();
      cmd_valid = 1'b0;
      nchk++;
      if (!acc) $display("FAIL push_timeout: tag=%h not accepted, required accept within 40 cycles", tag);
      else begin
         npass++;
         shadow = model(op, amt, data, shadow);
         exp_q.push_back({shadow, tag});
      end
   endtask

   task automatic drain();
      rsp_ready = 1'b1;
      for (int i = 0; i < 60 && exp_q.size() != 0; i++) step();
      nchk++;
      if (exp_q.size() != 0) $display("FAIL drain_timeout: %0d responses outstanding, required 0", exp_q.size());
      else npass++;
   endtask

   task automatic test_reset();
      reset = 1'b1; step(); step();
      nchk += 7;
      if (cmd_ready !== 1'b1)    $display("FAIL rst_cmd_ready: got %b, required 1", cmd_ready); else npass++;
      if (rsp_valid !== 1'b0)    $display("FAIL rst_rsp_valid: got %b, required 0", rsp_valid); else npass++;
      if (rsp_data !== 8'h00)    $display("FAIL rst_rsp_data: got %h, required 00", rsp_data); else npass++;
      if (rsp_tag !== '0)        $display("FAIL rst_rsp_tag: got %h, required 0", rsp_tag); else npass++;
      if ({reg_load, reg_shift_r_l, reg_sh, reg_d_in} !== 13'd0)
         $display("FAIL rst_reg_ctl: got %b, required 0", {reg_load, reg_shift_r_l, reg_sh, reg_d_in});
      else npass++;
      if (stat_count !== 16'd0)  $display("FAIL rst_stat_count: got %0d, required 0", stat_count); else npass++;
      if (reg_d_out !== 8'h00)   $display("FAIL rst_reg_value: got %h, required 00", reg_d_out); else npass++;
      reset = 1'b0;
      shadow = 8'h00; hs_cnt = 0;
   endtask

   task automatic test_load();
      load_cnt = 0; load_din = 8'h00;
      push(2'b01, 3'd0, 8'h81, 4'd1);
      drain();
      nchk += 2;
      if (load_cnt !== 1)      $display("FAIL t1_load_pulse: got %0d cycles, required 1", load_cnt); else npass++;
      if (load_din !== 8'h81)  $display("FAIL t1_d_in: got %h, required 81", load_din); else npass++;
   endtask

   task automatic test_shifts();
      push(2'b10, 3'd3, 8'hFF, 4'd2);
      drain();
      push(2'b01, 3'd0, 8'h81, 4'd3);
      push(2'b11, 3'd2, 8'h00, 4'd4);
      drain();
   endtask

   task automatic test_backpressure();
      logic [7:0] d0; logic [TW-1:0] t0;
      rsp_ready = 1'b0;
      push(2'b01, 3'd0, 8'h3C, 4'd0);
      push(2'b10, 3'd1, 8'h00, 4'd1);
      push(2'b11, 3'd2, 8'h00, 4'd2);
      push(2'b00, 3'd5, 8'hAA, 4'd3);
      push(2'b10, 3'd7, 8'h00, 4'd4);
      step(); step(); step();
      d0 = rsp_data; t0 = rsp_tag;
      nchk += 2;
      if (cmd_ready !== 1'b0) $display("FAIL t3_full: cmd_ready got %b, required 0", cmd_ready); else npass++;
      if (rsp_valid !== 1'b1) $display("FAIL t3_rsp_pending: rsp_valid got %b, required 1", rsp_valid); else npass++;
      step(); step(); step();
      nchk += 2;
      if ({rsp_data, rsp_tag} !== {d0, t0})
         $display("FAIL t3_rsp_stable: got %h/%h, required %h/%h", rsp_data, rsp_tag, d0, t0);
      else npass++;
      if (cmd_ready !== 1'b0) $display("FAIL t3_still_full: cmd_ready got %b, required 0", cmd_ready); else npass++;
      drain();
   endtask

   task automatic test_zero_shift();
      sh_seen = 1'b0;
      push(2'b01, 3'd0, 8'h5A, 4'd5);
      push(2'b10, 3'd0, 8'h00, 4'd6);
      push(2'b00, 3'd3, 8'h11, 4'd7);
      drain();
      nchk++;
      if (sh_seen !== 1'b0) $display("FAIL t4_sh_zero: nonzero reg_sh seen, required 0 throughout"); else npass++;
   endtask

   task automatic test_reset_mid_op();
      rsp_ready = 1'b0;
      push(2'b01, 3'd0, 8'hC3, 4'd8);
      push(2'b10, 3'd1, 8'h00, 4'd9);
      push(2'b11, 3'd1, 8'h00, 4'd10);
      nchk++;
      if (obs_load !== 1'b1) $display("FAIL t5_in_sample: previous cycle reg_load got %b, required 1", obs_load); else npass++;
      reset = 1'b1; step(); reset = 1'b0;
      exp_q.delete(); shadow = 8'h00; hs_cnt = 0;
      nchk += 3;
      if (rsp_valid !== 1'b0) $display("FAIL t5_rsp_valid: got %b, required 0", rsp_valid); else npass++;
      if (cmd_ready !== 1'b1) $display("FAIL t5_cmd_ready: got %b, required 1", cmd_ready); else npass++;
      if ({reg_load, reg_shift_r_l, reg_sh, reg_d_in} !== 13'd0)
         $display("FAIL t5_reg_ctl: got %b, required 0", {reg_load, reg_shift_r_l, reg_sh, reg_d_in});
      else npass++;
      rsp_ready = 1'b1; rsp_cnt = 0;
      for (int i = 0; i < 10; i++) step();
      nchk++;
      if (rsp_cnt !== 0) $display("FAIL t5_no_rsp: got %0d responses, required 0", rsp_cnt); else npass++;
   endtask

   task automatic test_stats();
      logic [15:0] exp_cnt;
      push(2'b01, 3'd0, 8'h0F, 4'd11);
      push(2'b11, 3'd4, 8'h00, 4'd12);
      push(2'b00, 3'd0, 8'h00, 4'd13);
      drain();
`ifdef SEQ_STATS_EN
      exp_cnt = 16'(hs_cnt);
`else
      exp_cnt = 16'd0;
`endif
      nchk++;
      if (stat_count !== exp_cnt) $display("FAIL t6_stat_count: got %0d, required %0d", stat_count, exp_cnt); else npass++;
   endtask

   initial begin
      reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_amt = 3'd0;
      cmd_data = 8'h00; cmd_tag = '0; rsp_ready = 1'b0;
      load_cnt = 0; rsp_cnt = 0; hs_cnt = 0; sh_seen = 1'b0; obs_load = 1'b0;
      acc = 1'b0; shadow = 8'h00; load_din = 8'h00;
      test_reset();
      test_load();
      test_shifts();
      test_backpressure();
      test_zero_shift();
      test_reset_mid_op();
      test_stats();
      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

endmodule
